anton_neopixel_stream_seq: RTL and testbench
============================================

// Module: anton_neopixel_stream_seq
// PURPOSE
//  Parametrised successor of the NeoPixel stream sequencer. Runs in the 6.4MHz pixel domain, walks the pixel buffer and
//  emits sub-bit, bit, channel and byte-address indices for the serialiser and buffer read port. Adds per-build channel
//  count (RGB/RGBW), a configurable channel-to-byte order map, one-shot vs loop framing and a frame-done pulse.
// PARAMETERS
//  BUFFER_END       1023   last valid byte address of pixel buffer; BUFFER_BITS = CLOG2(BUFFER_END+1)
//  CHANNELS         3      channels per pixel, 1..4 (3=GRB, 4=GRBW)
//  CHANNEL_ORDER    8'h21  field i = bits[2i+1:2i] = byte offset of transmitted channel i (default GRB from RGB memory)
//  BITS_PER_CHANNEL 8      bits per channel, 1..8
//  PATTERN_LEN      8      sub-bit steps per bit, 2..16
//  RESET_DELAY      1959   reset-state length in clocks minus 1 (>=1)
// PORTS
//  clk6_4mhz     in   1            pixel-domain clock
//  rstn          in   1            asynchronous active-low reset
//  ctrl_init     in   1            sync clear of sequencer (held >=1 clk)
//  ctrl_run      in   1            1=advance, 0=pause
//  ctrl_loop     in   1            1=restart after reset gap, 0=one frame then DONE
//  ctrl_limit    in   1            1=use reg_max as last byte, 0=BUFFER_END
//  ctrl_wide     in   1            1=pixel stride 4 bytes, 0=stride CHANNELS
//  reg_max       in   13           software last-byte limit; low BUFFER_BITS used
//  pattern_ix    out  4            sub-bit step 0..PATTERN_LEN-1
//  bit_ix        out  3            bit within channel, 0 = first sent (MSB)
//  channel_ix    out  2            transmitted channel 0..CHANNELS-1
//  byte_addr     out  BUFFER_BITS  pixel_base + CHANNEL_ORDER[channel_ix] (combinational from regs)
//  state         out  2            0 IDLE, 1 TRANSMIT, 2 RESET, 3 DONE
//  stream_out    out  1            TRANSMIT && ctrl_run && !ctrl_init
//  stream_reset  out  1            RESET && ctrl_run && !ctrl_init
//  bit_of, channel_of, pixel_of   out 1 each   1-clk overflow strobes (same cycle as last pattern step)
//  frame_done    out  1            1-clk pulse on RESET->DONE or RESET->TRANSMIT
//  init_done     out  1            1-clk pulse the cycle after ctrl_init falls
// BEHAVIOUR
//  - Reset (rstn=0, async): state=IDLE, all counters/pixel_base/delay=0, all outputs 0.
//  - IDLE: ctrl_run=1 -> TRANSMIT next clk, counters at 0. ctrl_init overrides everything: any state -> IDLE, counters 0.
//  - TRANSMIT, advancing only when stream_out=1: pattern_ix +1 per clk; at PATTERN_LEN-1 wraps, bit_ix +1;
//    bit_of when bit_ix=BITS_PER_CHANNEL-1; channel_of when bit_of && channel_ix=CHANNELS-1.
//  - last_pixel = (pixel_base + stride) > max_addr, computed BUFFER_BITS+1 wide (no wrap); max_addr per ctrl_limit.
//  - channel_of && !last_pixel: pixel_base += stride. channel_of && last_pixel: pixel_of=1, pixel_base=0, -> RESET.
//  - stride sampled from ctrl_wide each pixel; changing ctrl_wide/ctrl_limit mid-frame takes effect at next pixel boundary.
//  - RESET: delay counter +1 per clk while stream_reset; at RESET_DELAY: counter=0, frame_done, then ctrl_loop=1 ->
//    TRANSMIT, ctrl_loop=0 -> DONE. RESET lasts exactly RESET_DELAY+1 active clocks.
//  - DONE: outputs idle, indices 0; leaves to IDLE only when ctrl_run=0 (one-shot needs run toggle to restart).
//  - ctrl_run=0 in TRANSMIT/RESET: pause, all counters hold, stream_out/stream_reset=0; resume continues seamlessly.
//  - Single-pixel frame (max_addr < stride): first pixel is last; pixel_of after CHANNELS*BITS*PATTERN_LEN clocks.
//  - init_done asserted one clock after ctrl_init deasserts; rstn mid-frame aborts immediately, no frame_done.
// TESTING
//  1 Defaults, run=1, loop=1, limit=1, reg_max=5, wide=0: 2 pixels; byte_addr 1,0,2,4,3,5; pixel_of at clk 384, RESET 1960 clk.
//  2 CHANNELS=4, CHANNEL_ORDER=8'hE1, wide=1, reg_max=7: byte_addr 1,0,2,3,5,4,6,7; frame 512 clk.
//  3 loop=0, reg_max=2: one frame, frame_done once, state=DONE; drop run -> IDLE, raise run -> restarts at byte 1.
//  4 run=0 for 10 clk at pattern_ix=3 mid-bit: all indices hold, stream_out=0; resume exact, total length +10 clk.
//  5 ctrl_init pulse mid-TRANSMIT: next clk state=IDLE, counters 0; init_done 1 clk after init falls.
//  6 limit=0, BUFFER_END=1023, wide=1: last pixel base 1020, pixel_base returns to 0 without overflow.

Source files
------------

// File: rtl/anton_neopixel_stream_seq_if.sv
// Control/status bundle between the pixel-stream controller and the sequencer.
//   master: drives ctrl_* and reg_max, observes the sequencer indices and strobes
//   slave : the sequencer itself (anton_neopixel_stream_seq)
interface anton_neopixel_stream_seq_if #(
    parameter int unsigned BUFFER_BITS = 10
);
    localparam int unsigned REG_MAX_W  = 13;
    localparam int unsigned PATTERN_W  = 4;
    localparam int unsigned BIT_W      = 3;
    localparam int unsigned CHANNEL_W  = 2;
    localparam int unsigned STATE_W    = 2;

    logic                   ctrl_init;
    logic                   ctrl_run;
    logic                   ctrl_loop;
    logic                   ctrl_limit;
    logic                   ctrl_wide;
    logic [REG_MAX_W-1:0]   reg_max;

    logic [PATTERN_W-1:0]   pattern_ix;
    logic [BIT_W-1:0]       bit_ix;
    logic [CHANNEL_W-1:0]   channel_ix;
    logic [BUFFER_BITS-1:0] byte_addr;
    logic [STATE_W-1:0]     state;
    logic                   stream_out;
    logic                   stream_reset;
    logic                   bit_of;
    logic                   channel_of;
    logic                   pixel_of;
    logic                   frame_done;
    logic                   init_done;

    modport master (
        output ctrl_init, ctrl_run, ctrl_loop, ctrl_limit, ctrl_wide, reg_max,
        input  pattern_ix, bit_ix, channel_ix, byte_addr, state,
               stream_out, stream_reset, bit_of, channel_of, pixel_of,
               frame_done, init_done
    );

    modport slave (
        input  ctrl_init, ctrl_run, ctrl_loop, ctrl_limit, ctrl_wide, reg_max,
        output pattern_ix, bit_ix, channel_ix, byte_addr, state,
               stream_out, stream_reset, bit_of, channel_of, pixel_of,
               frame_done, init_done
    );
endinterface

// File: rtl/anton_neopixel_stream_seq.sv
// NeoPixel stream sequencer (6.4 MHz pixel domain). Walks the pixel buffer and
// produces sub-bit / bit / channel indices plus the buffer byte address for the
// serialiser, then holds the line in the reset gap between frames.
// Ports:
//   clk6_4mhz : pixel-domain clock
//   rstn      : asynchronous active-low reset
//   seq_if    : slave side of anton_neopixel_stream_seq_if
//               (ctrl_*/reg_max in; indices, byte_addr, state, strobes out)
module anton_neopixel_stream_seq #(
    parameter int unsigned BUFFER_END       = 1023,
    parameter int unsigned CHANNELS         = 3,
    parameter logic [7:0]  CHANNEL_ORDER    = 8'h21,
    parameter int unsigned BITS_PER_CHANNEL = 8,
    parameter int unsigned PATTERN_LEN      = 8,
    parameter int unsigned RESET_DELAY      = 1959
) (
    input  logic                             clk6_4mhz,
    input  logic                             rstn,
    anton_neopixel_stream_seq_if.slave       seq_if
);
    localparam int unsigned BUFFER_BITS = $clog2(BUFFER_END + 1);
    localparam int unsigned ADDR_W      = BUFFER_BITS + 1;
    localparam int unsigned DELAY_BITS  = $clog2(RESET_DELAY + 1);
    localparam int unsigned PATTERN_W   = 4;
    localparam int unsigned BIT_W       = 3;
    localparam int unsigned CHANNEL_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRANSMIT = 2'd1,
        ST_RESET    = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    state_e                 state_q,   state_d;
    logic [PATTERN_W-1:0]   pattern_q, pattern_d;
    logic [BIT_W-1:0]       bit_q,     bit_d;
    logic [CHANNEL_W-1:0]   chan_q,    chan_d;
    logic [BUFFER_BITS-1:0] base_q,    base_d;
    logic [DELAY_BITS-1:0]  delay_q,   delay_d;
    logic                   init_q;
    logic                   init_done_q;

    logic                   stream_out_c;
    logic                   stream_reset_c;
    logic                   pattern_last_c;
    logic                   bit_of_c;
    logic                   channel_of_c;
    logic                   pixel_of_c;
    logic                   delay_last_c;
    logic                   frame_done_c;
    logic [ADDR_W-1:0]      stride_c;
    logic [BUFFER_BITS-1:0] max_addr_c;
    logic                   last_pixel_c;
    logic [1:0]             order_off_c;

    // Qualified activity: a pause or a pending init freezes everything.
    assign stream_out_c   = (state_q == ST_TRANSMIT) && seq_if.ctrl_run && !seq_if.ctrl_init;
    assign stream_reset_c = (state_q == ST_RESET)    && seq_if.ctrl_run && !seq_if.ctrl_init;

    // Overflow chain; each strobe coincides with the final pattern step it closes.
    assign pattern_last_c = pattern_q == PATTERN_W'(PATTERN_LEN - 1);
    assign bit_of_c       = stream_out_c && pattern_last_c && (bit_q == BIT_W'(BITS_PER_CHANNEL - 1));
    assign channel_of_c   = bit_of_c && (chan_q == CHANNEL_W'(CHANNELS - 1));

    // Stride and limit are read live, so a change only matters at the next pixel boundary.
    assign stride_c     = ADDR_W'(seq_if.ctrl_wide ? 32'd4 : CHANNELS);
    assign max_addr_c   = seq_if.ctrl_limit ? BUFFER_BITS'(seq_if.reg_max) : BUFFER_BITS'(BUFFER_END);
    // One extra bit so a base near the top of the buffer cannot wrap past the limit.
    assign last_pixel_c = (ADDR_W'(base_q) + stride_c) > ADDR_W'(max_addr_c);
    assign pixel_of_c   = channel_of_c && last_pixel_c;

    assign delay_last_c = delay_q == DELAY_BITS'(RESET_DELAY);
    assign frame_done_c = stream_reset_c && delay_last_c;

    // Transmit order -> byte offset inside the pixel.
    assign order_off_c = CHANNEL_ORDER[{chan_q, 1'b0} +: 2];

    // State and counter registers.
    always_ff @(posedge clk6_4mhz or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            bit_q     <= '0;
            chan_q    <= '0;
            base_q    <= '0;
            delay_q   <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            bit_q     <= bit_d;
            chan_q    <= chan_d;
            base_q    <= base_d;
            delay_q   <= delay_d;
        end
    end

    // Falling-edge detect on ctrl_init.
    always_ff @(posedge clk6_4mhz or negedge rstn) begin
        if (!rstn) begin
            init_q      <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            init_q      <= seq_if.ctrl_init;
            init_done_q <= init_q && !seq_if.ctrl_init;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        bit_d     = bit_q;
        chan_d    = chan_q;
        base_d    = base_q;
        delay_d   = delay_q;

        if (seq_if.ctrl_init) begin
            state_d   = ST_IDLE;
            pattern_d = '0;
            bit_d     = '0;
            chan_d    = '0;
            base_d    = '0;
            delay_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (seq_if.ctrl_run) begin
                        state_d = ST_TRANSMIT;
                    end
                end
                ST_TRANSMIT: begin
                    if (stream_out_c) begin
                        if (pattern_last_c) begin
                            pattern_d = '0;
                            bit_d     = bit_q + BIT_W'(1);
                        end else begin
                            pattern_d = pattern_q + PATTERN_W'(1);
                        end
                        if (bit_of_c) begin
                            bit_d  = '0;
                            chan_d = chan_q + CHANNEL_W'(1);
                        end
                        if (channel_of_c) begin
                            chan_d = '0;
                            if (last_pixel_c) begin
                                base_d  = '0;
                                state_d = ST_RESET;
                            end else begin
                                base_d = base_q + BUFFER_BITS'(stride_c);
                            end
                        end
                    end
                end
                ST_RESET: begin
                    if (stream_reset_c) begin
                        if (delay_last_c) begin
                            delay_d = '0;
                            state_d = seq_if.ctrl_loop ? ST_TRANSMIT : ST_DONE;
                        end else begin
                            delay_d = delay_q + DELAY_BITS'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // One-shot frames need run dropped before another start.
                    if (!seq_if.ctrl_run) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign seq_if.pattern_ix   = pattern_q;
    assign seq_if.bit_ix       = bit_q;
    assign seq_if.channel_ix   = chan_q;
    assign seq_if.state        = state_q;
    assign seq_if.byte_addr    = (state_q == ST_TRANSMIT) ? (base_q + BUFFER_BITS'(order_off_c)) : '0;
    assign seq_if.stream_out   = stream_out_c;
    assign seq_if.stream_reset = stream_reset_c;
    assign seq_if.bit_of       = bit_of_c;
    assign seq_if.channel_of   = channel_of_c;
    assign seq_if.pixel_of     = pixel_of_c;
    assign seq_if.frame_done   = frame_done_c;
    assign seq_if.init_done    = init_done_q;

endmodule

// File: tb/tb_anton_neopixel_stream_seq.sv
// Scoreboard bench for anton_neopixel_stream_seq: default RGB build (dut0) and
// an RGBW build with a short reset gap (dut1). Stimulus pushes expected channel
// start addresses and strobe timings; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_anton_neopixel_stream_seq;
    localparam int unsigned BB = 10;
    localparam int EV_PIX  = 1;
    localparam int EV_FD   = 2;
    localparam int EV_INIT = 3;
    localparam int EV_K    = 100000;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    anton_neopixel_stream_seq_if #(.BUFFER_BITS(BB)) bus0();
    anton_neopixel_stream_seq_if #(.BUFFER_BITS(BB)) bus1();

    anton_neopixel_stream_seq dut0 (
        .clk6_4mhz (clk),
        .rstn      (rstn),
        .seq_if    (bus0)
    );

    anton_neopixel_stream_seq #(
        .CHANNELS      (4),
        .CHANNEL_ORDER (8'hE1),
        .RESET_DELAY   (99)
    ) dut1 (
        .clk6_4mhz (clk),
        .rstn      (rstn),
        .seq_if    (bus1)
    );

    logic [1:0]    st  [2];
    logic [3:0]    pat [2];
    logic [2:0]    bt  [2];
    logic [1:0]    ch  [2];
    logic [BB-1:0] ba  [2];
    logic [6:0]    strb[2];
    assign st[0]  = bus0.state;      assign st[1]  = bus1.state;
    assign pat[0] = bus0.pattern_ix; assign pat[1] = bus1.pattern_ix;
    assign bt[0]  = bus0.bit_ix;     assign bt[1]  = bus1.bit_ix;
    assign ch[0]  = bus0.channel_ix; assign ch[1]  = bus1.channel_ix;
    assign ba[0]  = bus0.byte_addr;  assign ba[1]  = bus1.byte_addr;
    // {stream_out, stream_reset, bit_of, channel_of, pixel_of, frame_done, init_done}
    assign strb[0] = {bus0.stream_out, bus0.stream_reset, bus0.bit_of, bus0.channel_of,
                      bus0.pixel_of, bus0.frame_done, bus0.init_done};
    assign strb[1] = {bus1.stream_out, bus1.stream_reset, bus1.bit_of, bus1.channel_of,
                      bus1.pixel_of, bus1.frame_done, bus1.init_done};

    int n_checks = 0;
    int n_fail   = 0;
    int addr_q[2][$];
    int ev_q[2][$];
    int tx_cnt[2];
    int rs_cnt[2];

    int t1_addr[6] = '{1, 0, 2, 4, 3, 5};
    int t2_addr[8] = '{1, 0, 2, 3, 5, 4, 6, 7};
    int t3_addr[3] = '{1, 0, 2};

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, why);
    endtask

    task automatic pop_ev(input int d, input int kind, input int val, input string name);
        int e;
        if (ev_q[d].size() == 0) begin
            fail_now($sformatf("dut%0d %s", d, name), $sformatf("unexpected strobe, count %0d", val));
        end else begin
            e = ev_q[d].pop_front();
            check($sformatf("dut%0d %s", d, name), kind * EV_K + val, e);
        end
    endtask

    // Monitor: channel starts carry an address, strobes carry a cycle count.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                if (st[d] == 2'd1) tx_cnt[d]++; else tx_cnt[d] = 0;
                if (st[d] == 2'd2) rs_cnt[d]++; else rs_cnt[d] = 0;
                if (strb[d][6] && pat[d] == 4'd0 && bt[d] == 3'd0) begin
                    if (addr_q[d].size() == 0)
                        fail_now($sformatf("dut%0d byte_addr", d),
                                 $sformatf("unexpected channel start at addr %0d", int'(ba[d])));
                    else
                        check($sformatf("dut%0d byte_addr", d), int'(ba[d]), addr_q[d].pop_front());
                end
                if (strb[d][2]) pop_ev(d, EV_PIX, tx_cnt[d], "pixel_of_at");
                if (strb[d][1]) pop_ev(d, EV_FD, rs_cnt[d], "frame_done_at");
                if (strb[d][0]) pop_ev(d, EV_INIT, 0, "init_done");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_st(input int d, input int s, input int max, input string name);
        for (int i = 0; i < max; i++) begin
            tick();
            if (int'(st[d]) == s) return;
        end
        fail_now(name, $sformatf("timeout waiting for state %0d, state %0d", s, int'(st[d])));
    endtask

    task automatic wait_mid(input int p, input int c, input int b, input string name);
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (int'(pat[0]) == p && int'(ch[0]) == c && int'(bt[0]) == b) return;
        end
        fail_now(name, "timeout waiting for index position");
    endtask

    initial begin
        bus0.ctrl_init = 1'b0; bus0.ctrl_run = 1'b0; bus0.ctrl_loop = 1'b0;
        bus0.ctrl_limit = 1'b0; bus0.ctrl_wide = 1'b0; bus0.reg_max = '0;
        bus1.ctrl_init = 1'b0; bus1.ctrl_run = 1'b0; bus1.ctrl_loop = 1'b0;
        bus1.ctrl_limit = 1'b0; bus1.ctrl_wide = 1'b0; bus1.reg_max = '0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset state", d), int'(st[d]), 0);
            check($sformatf("dut%0d reset indices", d), int'({pat[d], bt[d], ch[d]}), 0);
            check($sformatf("dut%0d reset byte_addr", d), int'(ba[d]), 0);
            check($sformatf("dut%0d reset strobes", d), int'(strb[d]), 0);
        end
        rstn = 1'b1;
        tick();

        // 1: two-pixel looping frame, then leave via one-shot on the second pass
        bus0.reg_max = 13'd5; bus0.ctrl_limit = 1'b1; bus0.ctrl_wide = 1'b0; bus0.ctrl_loop = 1'b1;
        for (int f = 0; f < 2; f++) begin
            foreach (t1_addr[i]) addr_q[0].push_back(t1_addr[i]);
            ev_q[0].push_back(EV_PIX * EV_K + 384);
            ev_q[0].push_back(EV_FD * EV_K + 1960);
        end
        bus0.ctrl_run = 1'b1;
        tick();
        check("t1 start state", int'(st[0]), 1);
        check("t1 first byte_addr", int'(ba[0]), 1);
        wait_st(0, 2, 500, "t1 enter reset");
        wait_st(0, 1, 2100, "t1 loop restart");
        bus0.ctrl_loop = 1'b0;
        wait_st(0, 3, 2500, "t1 done");
        repeat (5) tick();
        check("t1 done holds", int'(st[0]), 3);
        check("t1 done indices", int'({pat[0], bt[0], ch[0]}), 0);
        check("t1 done stream_out", int'(strb[0][6]), 0);

        // 3: one-shot single pixel, restart needs a run toggle
        bus0.ctrl_run = 1'b0;
        tick();
        check("t3 done->idle", int'(st[0]), 0);
        bus0.reg_max = 13'd2;
        foreach (t3_addr[i]) addr_q[0].push_back(t3_addr[i]);
        ev_q[0].push_back(EV_PIX * EV_K + 192);
        ev_q[0].push_back(EV_FD * EV_K + 1960);
        bus0.ctrl_run = 1'b1;
        wait_st(0, 3, 2500, "t3 done");
        repeat (20) tick();
        check("t3 stays done", int'(st[0]), 3);
        check("t3 strobes consumed", ev_q[0].size(), 0);
        bus0.ctrl_run = 1'b0;
        tick();
        check("t3 idle again", int'(st[0]), 0);
        foreach (t3_addr[i]) addr_q[0].push_back(t3_addr[i]);
        ev_q[0].push_back(EV_PIX * EV_K + 192);
        ev_q[0].push_back(EV_FD * EV_K + 1960);
        bus0.ctrl_run = 1'b1;
        tick();
        check("t3 restart state", int'(st[0]), 1);
        check("t3 restart byte_addr", int'(ba[0]), 1);
        wait_st(0, 3, 2500, "t3 second done");

        // 4: 10-clock pause at pattern step 3; frame stretches by exactly 10
        bus0.ctrl_run = 1'b0;
        tick();
        bus0.reg_max = 13'd5;
        foreach (t1_addr[i]) addr_q[0].push_back(t1_addr[i]);
        ev_q[0].push_back(EV_PIX * EV_K + 394);
        ev_q[0].push_back(EV_FD * EV_K + 1960);
        bus0.ctrl_run = 1'b1;
        wait_mid(3, 1, 2, "t4 find step");
        bus0.ctrl_run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4 pause pattern_ix", int'(pat[0]), 3);
            check("t4 pause bit_ix", int'(bt[0]), 2);
            check("t4 pause channel_ix", int'(ch[0]), 1);
            check("t4 pause stream_out", int'(strb[0][6]), 0);
        end
        bus0.ctrl_run = 1'b1;
        tick();
        check("t4 resume pattern_ix", int'(pat[0]), 4);
        wait_st(0, 3, 2500, "t4 done");
        bus0.ctrl_run = 1'b0;
        tick();

        // 5: ctrl_init mid-transmit
        bus0.ctrl_loop = 1'b1;
        addr_q[0].push_back(1);
        addr_q[0].push_back(0);
        ev_q[0].push_back(EV_INIT * EV_K);
        bus0.ctrl_run = 1'b1;
        wait_mid(0, 1, 2, "t5 find step");
        bus0.ctrl_init = 1'b1;
        tick();
        check("t5 init state", int'(st[0]), 0);
        check("t5 init indices", int'({pat[0], bt[0], ch[0]}), 0);
        check("t5 init byte_addr", int'(ba[0]), 0);
        check("t5 init stream_out", int'(strb[0][6]), 0);
        tick();
        check("t5 init overrides run", int'(st[0]), 0);
        bus0.ctrl_init = 1'b0;
        bus0.ctrl_run  = 1'b0;
        check("t5 init_done not early", int'(strb[0][0]), 0);
        tick();
        check("t5 init_done pulse", int'(strb[0][0]), 1);
        tick();
        check("t5 init_done width", int'(strb[0][0]), 0);
        check("t5 idle after init", int'(st[0]), 0);
        check("t5 partial frame starts", addr_q[0].size(), 0);
        bus0.ctrl_loop = 1'b0;

        // 2: RGBW build, order E1, stride 4
        bus1.reg_max = 13'd7; bus1.ctrl_limit = 1'b1; bus1.ctrl_wide = 1'b1; bus1.ctrl_loop = 1'b0;
        foreach (t2_addr[i]) addr_q[1].push_back(t2_addr[i]);
        ev_q[1].push_back(EV_PIX * EV_K + 512);
        ev_q[1].push_back(EV_FD * EV_K + 100);
        bus1.ctrl_run = 1'b1;
        wait_st(1, 3, 1000, "t2 done");
        bus1.ctrl_run = 1'b0;
        tick();

        // 6: full buffer, wide stride; last base 1020 must not wrap
        bus0.ctrl_limit = 1'b0; bus0.ctrl_wide = 1'b1;
        for (int b = 0; b <= 1020; b += 4) begin
            addr_q[0].push_back(b + 1);
            addr_q[0].push_back(b);
            addr_q[0].push_back(b + 2);
        end
        ev_q[0].push_back(EV_PIX * EV_K + 49152);
        ev_q[0].push_back(EV_FD * EV_K + 1960);
        bus0.ctrl_run = 1'b1;
        wait_st(0, 3, 60000, "t6 done");
        repeat (3) tick();
        check("t6 done state", int'(st[0]), 3);
        bus0.ctrl_run = 1'b0;
        tick();

        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d addresses left", d), addr_q[d].size(), 0);
            check($sformatf("dut%0d strobes left", d), ev_q[d].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
